// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// funct codes, ALU controls, mux selects and fault causes.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRC_B_RT      = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'd1;
    localparam logic [1:0] CAUSE_BAD_ADDR = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    function automatic logic opcode_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_HALT: ok = 1'b1;
            default:                                                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface multicycle_control_if;
    logic        run;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        alu_overflow;
    logic        mem_err_invalid_address;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_source;
    logic        mem_addr_sel;
    logic        mem_read_enabled;
    logic        mem_write_enabled;
    logic        reg_write_enabled;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_control;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] instr_count;

    modport master (
        input  run, opcode, funct, alu_zero, alu_overflow, mem_err_invalid_address,
        output ir_write, pc_write, pc_source, mem_addr_sel, mem_read_enabled,
               mem_write_enabled, reg_write_enabled, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_control, busy, halted, fault,
               fault_cause, instr_count
    );

    modport slave (
        output run, opcode, funct, alu_zero, alu_overflow, mem_err_invalid_address,
        input  ir_write, pc_write, pc_source, mem_addr_sel, mem_read_enabled,
               mem_write_enabled, reg_write_enabled, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_control, busy, halted, fault,
               fault_cause, instr_count
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU opcode selection per phase; R-type funct only matters in EXEC, while
// the illegal-funct flag is valid whenever the IR holds an R-type.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       illegal_funct
);
    logic [2:0] rtype_ctl;

    always_comb begin
        rtype_ctl     = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  rtype_ctl = ALU_ADD;
            FN_SUB:  rtype_ctl = ALU_SUB;
            FN_AND:  rtype_ctl = ALU_AND;
            FN_OR:   rtype_ctl = ALU_OR;
            FN_SLT:  rtype_ctl = ALU_SLT;
            default: illegal_funct = (opcode == OP_RTYPE);
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        if (state == S_EXEC) begin
            if (opcode == OP_RTYPE)
                alu_control = rtype_ctl;
            else if (opcode == OP_BEQ)
                alu_control = ALU_SUB;
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: one datapath phase per cycle, with fault
// detection, HALT handling and a retired-instruction counter.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input logic                  clock,
    input logic                  reset,
    multicycle_control_if.master bus
);
    state_t      state, state_nxt;
    logic [1:0]  cause_q, cause_nxt;
    logic [31:0] count_q;
    logic        retire;
    logic [2:0]  alu_ctl;
    logic        illegal_funct;
    logic        ovf_checked;
    state_t      next_instr;

    alu_decoder u_alu_decoder (
        .state         (state),
        .opcode        (bus.opcode),
        .funct         (bus.funct),
        .alu_control   (alu_ctl),
        .illegal_funct (illegal_funct)
    );

    // and/or/slt cannot overflow in a meaningful way, so only add/sub/addi trap
    assign ovf_checked = (bus.opcode == OP_ADDI) ||
                         ((bus.opcode == OP_RTYPE) &&
                          ((bus.funct == FN_ADD) || (bus.funct == FN_SUB)));
    assign next_instr  = bus.run ? S_FETCH : S_IDLE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cause_q <= CAUSE_NONE;
            count_q <= '0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            if (retire)
                count_q <= count_q + 32'd1;
        end
    end

    always_comb begin
        state_nxt             = state;
        cause_nxt             = cause_q;
        retire                = 1'b0;
        bus.ir_write          = 1'b0;
        bus.pc_write          = 1'b0;
        bus.pc_source         = PC_SRC_ALU;
        bus.mem_addr_sel      = 1'b0;
        bus.mem_read_enabled  = 1'b0;
        bus.mem_write_enabled = 1'b0;
        bus.reg_write_enabled = 1'b0;
        bus.reg_dst           = 1'b0;
        bus.mem_to_reg        = 1'b0;
        bus.alu_src_a         = 1'b0;
        bus.alu_src_b         = SRC_B_RT;

        case (state)
            S_IDLE: if (bus.run) state_nxt = S_FETCH;

            S_FETCH: begin
                bus.mem_read_enabled = 1'b1;
                bus.ir_write         = 1'b1;
                bus.alu_src_b        = SRC_B_FOUR;
                bus.pc_write         = 1'b1;
                if (bus.mem_err_invalid_address) begin
                    state_nxt = S_FAULT;
                    cause_nxt = CAUSE_BAD_ADDR;
                end else begin
                    state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                bus.alu_src_b = SRC_B_IMM_SH2;
                if (bus.opcode == OP_HALT) begin
                    state_nxt = S_HALTED;
                end else if (!opcode_legal(bus.opcode) || illegal_funct) begin
                    state_nxt = S_FAULT;
                    cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                case (bus.opcode)
                    OP_RTYPE, OP_ADDI: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = (bus.opcode == OP_ADDI) ? SRC_B_IMM : SRC_B_RT;
                        if (bus.alu_overflow && ovf_checked) begin
                            state_nxt = S_FAULT;
                            cause_nxt = CAUSE_OVERFLOW;
                        end else begin
                            state_nxt = S_WB;
                        end
                    end
                    OP_LW, OP_SW: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = SRC_B_IMM;
                        state_nxt     = S_MEM;
                    end
                    OP_BEQ: begin
                        bus.alu_src_a = 1'b1;
                        bus.pc_write  = bus.alu_zero;
                        bus.pc_source = PC_SRC_BRANCH;
                        retire        = 1'b1;
                        state_nxt     = next_instr;
                    end
                    OP_J: begin
                        bus.pc_write  = 1'b1;
                        bus.pc_source = PC_SRC_JUMP;
                        retire        = 1'b1;
                        state_nxt     = next_instr;
                    end
                    default: begin
                        state_nxt = S_FAULT;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end

            S_MEM: begin
                bus.mem_addr_sel      = 1'b1;
                bus.mem_write_enabled = (bus.opcode == OP_SW);
                bus.mem_read_enabled  = (bus.opcode != OP_SW);
                if (bus.mem_err_invalid_address) begin
                    state_nxt = S_FAULT;
                    cause_nxt = CAUSE_BAD_ADDR;
                end else if (bus.opcode == OP_SW) begin
                    retire    = 1'b1;
                    state_nxt = next_instr;
                end else begin
                    state_nxt = S_WB;
                end
            end

            S_WB: begin
                bus.reg_write_enabled = 1'b1;
                bus.reg_dst           = (bus.opcode == OP_RTYPE);
                bus.mem_to_reg        = (bus.opcode == OP_LW);
                retire                = 1'b1;
                state_nxt             = next_instr;
            end

            default: ;  // HALTED and FAULT hold until reset
        endcase
    end

    assign bus.alu_control = alu_ctl;
    assign bus.busy        = (state != S_IDLE) && (state != S_HALTED) && (state != S_FAULT);
    assign bus.halted      = (state == S_HALTED);
    assign bus.fault       = (state == S_FAULT);
    assign bus.fault_cause = cause_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle vector bench for multicycle_control: each record holds one
// cycle's inputs and the hand-derived control outputs for that cycle.
module tb_multicycle_control;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multicycle_control_if bus();
    multicycle_control dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct packed {
        logic        ir_write;
        logic        pc_write;
        logic [1:0]  pc_source;
        logic        mem_addr_sel;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_we;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [2:0]  alu_control;
        logic        busy;
        logic        halted;
        logic        fault;
        logic [1:0]  fault_cause;
        logic [31:0] instr_count;
    } exp_t;

    typedef struct packed {
        logic       run;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       ov;
        logic       me;
        exp_t       e;
    } vec_t;

    exp_t act;
    assign act = {bus.ir_write, bus.pc_write, bus.pc_source, bus.mem_addr_sel,
                  bus.mem_read_enabled, bus.mem_write_enabled, bus.reg_write_enabled,
                  bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                  bus.alu_control, bus.busy, bus.halted, bus.fault,
                  bus.fault_cause, bus.instr_count};

    vec_t tbl[$];
    int   total = 0;
    int   passed = 0;

    // expected outputs per phase
    function automatic exp_t e_idle(input int c);
        exp_t e = '0; e.instr_count = c; return e;
    endfunction
    function automatic exp_t e_fetch(input int c);
        exp_t e = '0; e.ir_write = 1; e.pc_write = 1; e.mem_rd = 1;
        e.alu_src_b = 2'd1; e.busy = 1; e.instr_count = c; return e;
    endfunction
    function automatic exp_t e_decode(input int c);
        exp_t e = '0; e.alu_src_b = 2'd3; e.busy = 1; e.instr_count = c; return e;
    endfunction
    function automatic exp_t e_exr(input logic [2:0] alu, input int c);
        exp_t e = '0; e.alu_src_a = 1; e.alu_control = alu; e.busy = 1;
        e.instr_count = c; return e;
    endfunction
    function automatic exp_t e_exi(input int c);
        exp_t e = '0; e.alu_src_a = 1; e.alu_src_b = 2'd2; e.busy = 1;
        e.instr_count = c; return e;
    endfunction
    function automatic exp_t e_beq(input logic z, input int c);
        exp_t e = '0; e.alu_src_a = 1; e.alu_control = 3'd1; e.pc_write = z;
        e.pc_source = 2'd1; e.busy = 1; e.instr_count = c; return e;
    endfunction
    function automatic exp_t e_j(input int c);
        exp_t e = '0; e.pc_write = 1; e.pc_source = 2'd2; e.busy = 1;
        e.instr_count = c; return e;
    endfunction
    function automatic exp_t e_mem(input logic wr, input int c);
        exp_t e = '0; e.mem_addr_sel = 1; e.mem_rd = !wr; e.mem_wr = wr; e.busy = 1;
        e.instr_count = c; return e;
    endfunction
    function automatic exp_t e_wb(input logic dst, input logic m2r, input int c);
        exp_t e = '0; e.reg_we = 1; e.reg_dst = dst; e.mem_to_reg = m2r; e.busy = 1;
        e.instr_count = c; return e;
    endfunction
    function automatic exp_t e_halt(input int c);
        exp_t e = '0; e.halted = 1; e.instr_count = c; return e;
    endfunction
    function automatic exp_t e_fault(input logic [1:0] cause, input int c);
        exp_t e = '0; e.fault = 1; e.fault_cause = cause; e.instr_count = c; return e;
    endfunction

    task automatic v(input logic run, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic ov, input logic me, input exp_t e);
        vec_t t;
        t.run = run; t.op = op; t.fn = fn; t.z = z; t.ov = ov; t.me = me; t.e = e;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input exp_t e);
        total++;
        if (act === e) passed++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, e);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            bus.run = tbl[i].run; bus.opcode = tbl[i].op; bus.funct = tbl[i].fn;
            bus.alu_zero = tbl[i].z; bus.alu_overflow = tbl[i].ov;
            bus.mem_err_invalid_address = tbl[i].me;
            #1 check(name, i, tbl[i].e);
        end
        tbl.delete();
    endtask

    // asynchronous reset mid-cycle, checked before any clock edge
    task automatic do_reset(input string name);
        #2 reset = 1'b1; bus.run = 1'b0;
        #1 check(name, 0, e_idle(0));
        @(negedge clock) reset = 1'b0;
    endtask

    // R-type: 4 cycles starting in FETCH
    task automatic instr_r(input logic [5:0] fn, input logic [2:0] alu,
                           input logic ov, input int c);
        v(1, 6'h00, fn, 0, 0, 0, e_fetch(c));
        v(1, 6'h00, fn, 0, 0, 0, e_decode(c));
        v(1, 6'h00, fn, 0, ov, 0, e_exr(alu, c));
        v(1, 6'h00, fn, 0, 0, 0, e_wb(1, 0, c));
    endtask

    initial begin
        bus.run = 0; bus.opcode = 0; bus.funct = 0; bus.alu_zero = 0;
        bus.alu_overflow = 0; bus.mem_err_invalid_address = 0;
        #1 check("reset_state", 0, e_idle(0));
        repeat (2) @(negedge clock);
        reset = 1'b0;

        v(0, 6'h00, 6'h20, 0, 0, 0, e_idle(0));
        v(1, 6'h00, 6'h20, 0, 0, 0, e_idle(0));
        instr_r(6'h20, 3'd0, 0, 0);                      // add
        v(1, 6'h23, 0, 0, 0, 0, e_fetch(1));             // lw
        v(1, 6'h23, 0, 0, 0, 0, e_decode(1));
        v(1, 6'h23, 0, 0, 0, 0, e_exi(1));
        v(1, 6'h23, 0, 0, 0, 0, e_mem(0, 1));
        v(1, 6'h23, 0, 0, 0, 0, e_wb(0, 1, 1));
        v(1, 6'h2B, 0, 0, 0, 0, e_fetch(2));             // sw
        v(1, 6'h2B, 0, 0, 0, 0, e_decode(2));
        v(1, 6'h2B, 0, 0, 0, 0, e_exi(2));
        v(1, 6'h2B, 0, 0, 0, 0, e_mem(1, 2));
        v(1, 6'h04, 0, 1, 0, 0, e_fetch(3));             // beq taken
        v(1, 6'h04, 0, 1, 0, 0, e_decode(3));
        v(1, 6'h04, 0, 1, 0, 0, e_beq(1, 3));
        v(1, 6'h04, 0, 0, 0, 0, e_fetch(4));             // beq not taken
        v(1, 6'h04, 0, 0, 0, 0, e_decode(4));
        v(1, 6'h04, 0, 0, 0, 0, e_beq(0, 4));
        v(1, 6'h02, 0, 0, 0, 0, e_fetch(5));             // j
        v(1, 6'h02, 0, 0, 0, 0, e_decode(5));
        v(1, 6'h02, 0, 0, 0, 0, e_j(5));
        instr_r(6'h22, 3'd1, 0, 6);                      // sub
        instr_r(6'h24, 3'd2, 1, 7);                      // and ignores overflow
        instr_r(6'h25, 3'd3, 0, 8);                      // or
        instr_r(6'h2A, 3'd4, 0, 9);                      // slt
        v(1, 6'h08, 0, 0, 0, 0, e_fetch(10));            // addi, no overflow
        v(1, 6'h08, 0, 0, 0, 0, e_decode(10));
        v(1, 6'h08, 0, 0, 0, 0, e_exi(10));
        v(1, 6'h08, 0, 0, 0, 0, e_wb(0, 0, 10));
        v(1, 6'h23, 0, 0, 0, 0, e_fetch(11));            // lw with run dropped
        v(0, 6'h23, 0, 0, 0, 0, e_decode(11));
        v(0, 6'h23, 0, 0, 0, 0, e_exi(11));
        v(0, 6'h23, 0, 0, 0, 0, e_mem(0, 11));
        v(0, 6'h23, 0, 0, 0, 0, e_wb(0, 1, 11));
        v(0, 6'h23, 0, 0, 0, 0, e_idle(12));
        v(1, 6'h3F, 0, 0, 0, 0, e_idle(12));             // HALT
        v(1, 6'h3F, 0, 0, 0, 0, e_fetch(12));
        v(1, 6'h3F, 0, 0, 0, 0, e_decode(12));
        v(1, 6'h3F, 0, 0, 0, 0, e_halt(12));
        v(1, 6'h00, 6'h20, 0, 0, 0, e_halt(12));
        run_table("main");
        do_reset("reset_from_halt");

        v(1, 6'h08, 0, 0, 0, 0, e_idle(0));
        v(1, 6'h08, 0, 0, 0, 0, e_fetch(0));
        v(1, 6'h08, 0, 0, 0, 0, e_decode(0));
        v(1, 6'h08, 0, 0, 1, 0, e_exi(0));
        v(1, 6'h08, 0, 0, 0, 0, e_fault(2'd1, 0));
        v(1, 6'h08, 0, 0, 0, 0, e_fault(2'd1, 0));
        run_table("addi_overflow");
        do_reset("reset_from_fault");

        v(1, 6'h3E, 0, 0, 0, 0, e_idle(0));
        v(1, 6'h3E, 0, 0, 0, 0, e_fetch(0));
        v(1, 6'h3E, 0, 0, 0, 0, e_decode(0));
        v(1, 6'h3E, 0, 0, 0, 0, e_fault(2'd3, 0));
        v(1, 6'h3E, 0, 0, 0, 0, e_fault(2'd3, 0));
        run_table("illegal_opcode");
        do_reset("reset_2");

        v(1, 6'h00, 6'h21, 0, 0, 0, e_idle(0));
        v(1, 6'h00, 6'h21, 0, 0, 0, e_fetch(0));
        v(1, 6'h00, 6'h21, 0, 0, 0, e_decode(0));
        v(1, 6'h00, 6'h21, 0, 0, 0, e_fault(2'd3, 0));
        run_table("illegal_funct");
        do_reset("reset_3");

        v(1, 6'h23, 0, 0, 0, 0, e_idle(0));
        v(1, 6'h23, 0, 0, 0, 0, e_fetch(0));
        v(1, 6'h23, 0, 0, 0, 0, e_decode(0));
        v(1, 6'h23, 0, 0, 0, 0, e_exi(0));
        v(1, 6'h23, 0, 0, 0, 1, e_mem(0, 0));
        v(1, 6'h23, 0, 0, 0, 0, e_fault(2'd2, 0));
        v(1, 6'h23, 0, 0, 0, 0, e_fault(2'd2, 0));
        run_table("mem_bad_addr");
        do_reset("reset_4");

        v(1, 6'h00, 6'h20, 0, 0, 0, e_idle(0));
        v(1, 6'h00, 6'h20, 0, 0, 1, e_fetch(0));
        v(1, 6'h00, 6'h20, 0, 0, 0, e_fault(2'd2, 0));
        run_table("fetch_bad_addr");
        do_reset("reset_5");

        v(1, 6'h00, 6'h22, 0, 0, 0, e_idle(0));
        v(1, 6'h00, 6'h22, 0, 0, 0, e_fetch(0));
        v(1, 6'h00, 6'h22, 0, 0, 0, e_decode(0));
        v(1, 6'h00, 6'h22, 0, 1, 0, e_exr(3'd1, 0));
        v(1, 6'h00, 6'h22, 0, 0, 0, e_fault(2'd1, 0));
        run_table("sub_overflow");
        do_reset("reset_6");

        // add interrupted by reset in EXEC: nothing retires, no WB follows
        v(1, 6'h00, 6'h20, 0, 0, 0, e_idle(0));
        v(1, 6'h00, 6'h20, 0, 0, 0, e_fetch(0));
        v(1, 6'h00, 6'h20, 0, 0, 0, e_decode(0));
        v(1, 6'h00, 6'h20, 0, 0, 0, e_exr(3'd0, 0));
        run_table("pre_reset_exec");
        do_reset("reset_mid_exec");
        v(0, 6'h00, 6'h20, 0, 0, 0, e_idle(0));
        v(0, 6'h00, 6'h20, 0, 0, 0, e_idle(0));
        run_table("after_reset_exec");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
